user_spi_tx_queue: RTL and testbench

- OBI-mapped transmit queue placed directly upstream of the user-domain SPI byte shifter that drives the SSD1331 OLED.
- Software pushes {dc, byte} entries through the OBI subordinate port. The block drains them to the shifter over a valid/ready byte stream and holds the OLED D/C line stable per byte.
- Provides fill status, a sticky overflow flag and a low-watermark interrupt, so the CPU can refill in bursts instead of polling per byte.

---
 rtl/user_pkg.sv | 25 ++
 rtl/user_spi_tx_fifo.sv | 51 +++++
 rtl/user_spi_tx_queue.sv | 123 ++++++++++++
 tb/tb_user_spi_tx_queue.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/user_pkg.sv
// user_pkg: register map, bit positions and entry type for the SPI transmit queue
package user_pkg;

    localparam logic [1:0] TxDataOffset = 2'd0;
    localparam logic [1:0] StatusOffset = 2'd1;
    localparam logic [1:0] CtrlOffset   = 2'd2;

    localparam int StatusEmptyBit = 16;
    localparam int StatusFullBit  = 17;
    localparam int StatusBusyBit  = 18;
    localparam int StatusOvfBit   = 19;

    localparam int CtrlEnBit    = 0;
    localparam int CtrlFlushBit = 1;
    localparam int CtrlThrLsb   = 8;
    localparam int CtrlIrqEnBit = 16;

    localparam int TxDcBit = 8;

    typedef struct packed {
        logic       dc;
        logic [7:0] data;
    } tx_entry_t;

endpackage

// File: rtl/user_spi_tx_fifo.sv
// user_spi_tx_fifo: synchronous FIFO with level/empty/full and flush
//   clk, rst      : clock, synchronous active-high reset
//   push, din     : write din when not full
//   pop           : drop head when not empty
//   flush         : discard every stored entry
//   head          : current head entry (combinational from storage)
//   level/empty/full : fill status
module user_spi_tx_fifo
    import user_pkg::*;
#(
    parameter int  Depth    = 16,
    parameter type entry_t  = tx_entry_t,
    localparam int LvlWidth = $clog2(Depth) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  entry_t              din,
    input  logic                pop,
    input  logic                flush,
    output entry_t              head,
    output logic [LvlWidth-1:0] level,
    output logic                empty,
    output logic                full
);

    entry_t              mem [Depth];
    logic [LvlWidth-1:0] wr_ptr, rd_ptr;

    // Pointers carry one extra bit so full and empty differ; they wrap modulo 2*Depth.
    assign level = wr_ptr - rd_ptr;
    assign empty = level == '0;
    assign full  = level == LvlWidth'(Depth);
    assign head  = mem[rd_ptr[LvlWidth-2:0]];

    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[LvlWidth-2:0]] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + 1'b1;
            if (flush) rd_ptr <= wr_ptr;
            else if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/user_spi_tx_queue.sv
// user_spi_tx_queue: OBI-mapped {dc, byte} transmit queue feeding the OLED SPI shifter
//   clk_i, rst_i           : clock, synchronous active-high reset
//   req_i..aid_i, gnt_o..err_o : OBI subordinate port (TXDATA, STATUS, CTRL)
//   byte_o, byte_dc_o, byte_valid_o, byte_ready_i : byte stream to the shifter
//   spi_dc_o               : OLED D/C line, updated on each stream handshake
//   irq_o                  : low-watermark interrupt (level)
module user_spi_tx_queue
    import user_pkg::*;
#(
    parameter int Depth    = 16,
    parameter int AidWidth = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_i,
    input  logic                we_i,
    input  logic [3:0]          be_i,
    input  logic [31:0]         addr_i,
    input  logic [31:0]         wdata_i,
    input  logic [AidWidth-1:0] aid_i,
    output logic                gnt_o,
    output logic                rvalid_o,
    output logic [31:0]         rdata_o,
    output logic [AidWidth-1:0] rid_o,
    output logic                err_o,
    output logic [7:0]          byte_o,
    output logic                byte_dc_o,
    output logic                byte_valid_o,
    input  logic                byte_ready_i,
    output logic                spi_dc_o,
    output logic                irq_o
);

    localparam int LvlWidth = $clog2(Depth) + 1;

    tx_entry_t           head;
    logic [LvlWidth-1:0] level;
    logic                empty, full;
    logic                en_q, irq_en_q, ovf_q, hold_q;
    logic [7:0]          thr_q;
    logic [1:0]          sel;
    logic                wr_tx, wr_status, wr_ctrl, push, flush, hs;
    logic [31:0]         status_word, ctrl_word, rdata_d;
    logic                err_d;
    logic                unused;

    assign unused = ^{be_i, addr_i[31:4], addr_i[1:0], wdata_i[31:20], wdata_i[18:17]};

    assign gnt_o     = req_i;
    assign sel       = addr_i[3:2];
    assign wr_tx     = req_i && we_i && sel == TxDataOffset;
    assign wr_status = req_i && we_i && sel == StatusOffset;
    assign wr_ctrl   = req_i && we_i && sel == CtrlOffset;
    assign push      = wr_tx && !full;
    assign flush     = wr_ctrl && wdata_i[CtrlFlushBit];

    // Once offered, a byte stays offered until taken even if enable drops.
    assign byte_valid_o = !empty && (en_q || hold_q);
    assign hs           = byte_valid_o && byte_ready_i;
    assign byte_o       = head.data;
    assign byte_dc_o    = head.dc;

    user_spi_tx_fifo #(.Depth(Depth), .entry_t(tx_entry_t)) u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (push),
        .din   (tx_entry_t'({wdata_i[TxDcBit], wdata_i[7:0]})),
        .pop   (hs),
        .flush (flush),
        .head  (head),
        .level (level),
        .empty (empty),
        .full  (full)
    );

    always_comb begin
        status_word                 = '0;
        status_word[LvlWidth-1:0]   = level;
        status_word[StatusEmptyBit] = empty;
        status_word[StatusFullBit]  = full;
        status_word[StatusBusyBit]  = !empty || byte_valid_o;
        status_word[StatusOvfBit]   = ovf_q;
        ctrl_word                   = '0;
        ctrl_word[CtrlEnBit]        = en_q;
        ctrl_word[CtrlThrLsb+:8]    = thr_q;
        ctrl_word[CtrlIrqEnBit]     = irq_en_q;
    end

    assign rdata_d = we_i ? '0 : sel == StatusOffset ? status_word : sel == CtrlOffset ? ctrl_word : '0;
    assign err_d   = sel == 2'd3 || (wr_tx && full);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rvalid_o <= 1'b0;
            rdata_o  <= '0;
            rid_o    <= '0;
            err_o    <= 1'b0;
            en_q     <= 1'b0;
            irq_en_q <= 1'b0;
            thr_q    <= '0;
            ovf_q    <= 1'b0;
            hold_q   <= 1'b0;
            spi_dc_o <= 1'b0;
            irq_o    <= 1'b0;
        end else begin
            rvalid_o <= req_i;
            rdata_o  <= req_i ? rdata_d : '0;
            rid_o    <= req_i ? aid_i : '0;
            err_o    <= req_i && err_d;
            if (wr_ctrl) begin
                en_q     <= wdata_i[CtrlEnBit];
                thr_q    <= wdata_i[CtrlThrLsb+:8];
                irq_en_q <= wdata_i[CtrlIrqEnBit];
            end
            if (wr_tx && full) ovf_q <= 1'b1;
            else if (wr_status && wdata_i[StatusOvfBit]) ovf_q <= 1'b0;
            hold_q <= byte_valid_o && !byte_ready_i && !flush;
            if (hs) spi_dc_o <= byte_dc_o;
            irq_o <= irq_en_q && (9'(level) <= {1'b0, thr_q});
        end
    end

endmodule

// File: tb/tb_user_spi_tx_queue.sv
// tb_user_spi_tx_queue: directed self-checking bench for the SPI transmit queue
module tb_user_spi_tx_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0, we = 1'b0, aid = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic        gnt, rvalid, rid, err;
    logic [31:0] rdata;
    logic [7:0]  byte_d;
    logic        byte_dc, byte_valid, spi_dc, irq;
    logic        ready = 1'b0;

    int checks = 0;
    int errors = 0;

    logic        g, rv, e, ri;
    logic [31:0] rd;

    always #5 clk = ~clk;

    user_spi_tx_queue #(.Depth(16), .AidWidth(1)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_i        (req),
        .we_i         (we),
        .be_i         (4'hF),
        .addr_i       (addr),
        .wdata_i      (wdata),
        .aid_i        (aid),
        .gnt_o        (gnt),
        .rvalid_o     (rvalid),
        .rdata_o      (rdata),
        .rid_o        (rid),
        .err_o        (err),
        .byte_o       (byte_d),
        .byte_dc_o    (byte_dc),
        .byte_valid_o (byte_valid),
        .byte_ready_i (ready),
        .spi_dc_o     (spi_dc),
        .irq_o        (irq)
    );

    // One OBI access; returns grant seen before the edge and the response sampled 1 ns after it.
    task automatic obi(input logic w, input logic [3:0] off, input logic [31:0] wd, input logic id);
        @(negedge clk);
        req = 1'b1; we = w; addr = {28'h0, off}; wdata = wd; aid = id;
        #1 g = gnt;
        @(posedge clk);
        #1;
        rv = rvalid; rd = rdata; e = err; ri = rid;
        req = 1'b0; we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        checks++; if ({byte_valid, spi_dc, irq, rvalid} !== 4'b0) begin errors++; $display("FAIL reset_outputs got %b exp 0000", {byte_valid, spi_dc, irq, rvalid}); end
        obi(1'b0, 4'h4, 32'h0, 1'b1);
        checks++; if (g !== 1'b1) begin errors++; $display("FAIL reset_gnt got %b exp 1", g); end
        checks++; if (rv !== 1'b1) begin errors++; $display("FAIL reset_rvalid got %b exp 1", rv); end
        checks++; if (rd !== 32'h0001_0000) begin errors++; $display("FAIL reset_status got %h exp 00010000", rd); end
        checks++; if (ri !== 1'b1) begin errors++; $display("FAIL reset_rid got %b exp 1", ri); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", e); end
        @(posedge clk); #1;
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL rvalid_drop got %b exp 0", rvalid); end
    endtask

    task automatic test_stream();
        logic [7:0] exp_b [3] = '{8'hAE, 8'hFF, 8'h12};
        logic       exp_dc [3] = '{1'b0, 1'b1, 1'b0};
        obi(1'b1, 4'h0, 32'h0AE, 1'b0);
        obi(1'b1, 4'h0, 32'h1FF, 1'b0);
        obi(1'b1, 4'h0, 32'h012, 1'b0);
        checks++; if (byte_valid !== 1'b0) begin errors++; $display("FAIL stream_disabled got %b exp 0", byte_valid); end
        obi(1'b0, 4'h4, 32'h0, 1'b0);
        checks++; if (rd !== 32'h0004_0003) begin errors++; $display("FAIL stream_level3 got %h exp 00040003", rd); end
        ready = 1'b1;
        obi(1'b1, 4'h8, 32'h1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checks++; if ({byte_valid, byte_dc, byte_d} !== {1'b1, exp_dc[i], exp_b[i]}) begin errors++; $display("FAIL stream_byte%0d got %b/%b/%h exp 1/%b/%h", i, byte_valid, byte_dc, byte_d, exp_dc[i], exp_b[i]); end
            @(posedge clk); #1;
            checks++; if (spi_dc !== exp_dc[i]) begin errors++; $display("FAIL stream_spidc%0d got %b exp %b", i, spi_dc, exp_dc[i]); end
        end
        checks++; if (byte_valid !== 1'b0) begin errors++; $display("FAIL stream_drained got %b exp 0", byte_valid); end
        ready = 1'b0;
    endtask

    task automatic test_overflow();
        obi(1'b1, 4'h8, 32'h0, 1'b0);
        for (int i = 0; i < 17; i++) begin
            obi(1'b1, 4'h0, 32'(i), 1'b0);
            checks++; if (e !== (i == 16)) begin errors++; $display("FAIL ovf_push%0d err got %b exp %b", i, e, i == 16); end
        end
        obi(1'b0, 4'h4, 32'h0, 1'b0);
        checks++; if (rd !== 32'h000E_0010) begin errors++; $display("FAIL ovf_status got %h exp 000e0010", rd); end
        obi(1'b1, 4'h4, 32'h0008_0000, 1'b0);
        obi(1'b0, 4'h4, 32'h0, 1'b0);
        checks++; if (rd !== 32'h0006_0010) begin errors++; $display("FAIL ovf_clear got %h exp 00060010", rd); end
    endtask

    task automatic test_hold();
        obi(1'b1, 4'h8, 32'h1, 1'b0);
        checks++; if ({byte_valid, byte_d} !== {1'b1, 8'h00}) begin errors++; $display("FAIL hold_offer got %b/%h exp 1/00", byte_valid, byte_d); end
        obi(1'b1, 4'h8, 32'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        checks++; if (byte_valid !== 1'b1) begin errors++; $display("FAIL hold_stays got %b exp 1", byte_valid); end
        @(negedge clk) ready = 1'b1;
        @(posedge clk); #1 ready = 1'b0;
        checks++; if (byte_valid !== 1'b0) begin errors++; $display("FAIL hold_release got %b exp 0", byte_valid); end
        obi(1'b0, 4'h4, 32'h0, 1'b0);
        checks++; if (rd !== 32'h0004_000F) begin errors++; $display("FAIL hold_level15 got %h exp 0004000f", rd); end
    endtask

    task automatic test_irq();
        obi(1'b1, 4'h8, 32'h2, 1'b0);
        obi(1'b1, 4'h8, 32'h0001_0200, 1'b0);
        @(posedge clk); #1;
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_empty got %b exp 1", irq); end
        for (int i = 0; i < 5; i++) obi(1'b1, 4'h0, 32'h50 + 32'(i), 1'b0);
        @(posedge clk); #1;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_level5 got %b exp 0", irq); end
        ready = 1'b1;
        obi(1'b1, 4'h8, 32'h0001_0201, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            checks++; if (irq !== (k == 4)) begin errors++; $display("FAIL irq_drain%0d got %b exp %b", k, irq, k == 4); end
        end
        repeat (3) @(posedge clk);
        #1 ready = 1'b0;
        checks++; if (byte_valid !== 1'b0) begin errors++; $display("FAIL irq_drained got %b exp 0", byte_valid); end
    endtask

    task automatic test_flush();
        obi(1'b1, 4'h8, 32'h0, 1'b0);
        for (int i = 0; i < 8; i++) obi(1'b1, 4'h0, 32'h140 + 32'(i), 1'b0);
        obi(1'b1, 4'h8, 32'h1, 1'b0);
        checks++; if (byte_valid !== 1'b1) begin errors++; $display("FAIL flush_pre_valid got %b exp 1", byte_valid); end
        obi(1'b1, 4'h8, 32'h3, 1'b0);
        checks++; if (byte_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b exp 0", byte_valid); end
        obi(1'b0, 4'h4, 32'h0, 1'b0);
        checks++; if (rd !== 32'h0001_0000) begin errors++; $display("FAIL flush_status got %h exp 00010000", rd); end
        obi(1'b0, 4'h8, 32'h0, 1'b1);
        checks++; if ({ri, rd} !== {1'b1, 32'h1}) begin errors++; $display("FAIL flush_ctrl_read got %b/%h exp 1/00000001", ri, rd); end
        obi(1'b0, 4'hC, 32'h0, 1'b0);
        checks++; if ({e, rd} !== {1'b1, 32'h0}) begin errors++; $display("FAIL bad_read got %b/%h exp 1/00000000", e, rd); end
        obi(1'b1, 4'hC, 32'hFFFF_FFFF, 1'b0);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL bad_write got %b exp 1", e); end
        obi(1'b0, 4'h0, 32'h0, 1'b0);
        checks++; if ({e, rd} !== {1'b0, 32'h0}) begin errors++; $display("FAIL txdata_read got %b/%h exp 0/00000000", e, rd); end
        obi(1'b0, 4'h8, 32'h0, 1'b0);
        checks++; if (rd !== 32'h1) begin errors++; $display("FAIL bad_write_noeffect got %h exp 00000001", rd); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_overflow();
        test_hold();
        test_irq();
        test_flush();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
